// File: rtl/dcache_controller.sv
// Data cache miss-handling controller.
// Serves hits in zero cycles from IDLE. A miss is handled as an optional victim writeback,
// then a block fill from dmem, then a one-cycle cache refill. The CPU keeps its request
// held and replays it in IDLE once the refill is done.
// Optional feature: define DCACHE_PERF_COUNTERS_EN to build the hit/miss counters.
// Without it, hit_count and miss_count are tied to zero.
module dcache_controller #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cpu_re,
  input  logic        cpu_we,
  input  logic        hit,
  input  logic        victim_dirty,
  output logic        stall,
  output logic        cache_we,
  output logic        cache_update,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] FILL      = 2'd2;
  localparam logic [1:0] UPDATE    = 2'd3;

  // The down-counter is loaded with latency-1, so a phase ends on the cycle it reads zero.
  localparam logic [3:0] LAT_LAST = 4'(MEM_LATENCY - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       req;
  logic       req_hit;
  logic       req_miss;

  // A store has priority when both cpu_re and cpu_we are high.
  // cache_we follows cpu_we, so this priority needs no extra logic.
  assign req      = cpu_re | cpu_we;
  assign req_hit  = (state_q == IDLE) & req & hit;
  assign req_miss = (state_q == IDLE) & req & ~hit;

  // Next-state logic. victim_dirty is only looked at when a miss leaves IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_miss) begin
          state_d = victim_dirty ? WRITEBACK : FILL;
          cnt_d   = LAT_LAST;
        end
      end
      WRITEBACK: begin
        if (cnt_q == 4'd0) begin
          state_d = FILL;
          cnt_d   = LAT_LAST;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      FILL: begin
        if (cnt_q == 4'd0) begin
          state_d = UPDATE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      UPDATE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latency-counter registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output decode. Every output is forced low while reset is asserted.
  always_comb begin
    stall        = 1'b0;
    cache_we     = 1'b0;
    cache_update = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    if (!RST) begin
      case (state_q)
        IDLE: begin
          stall    = req_miss;
          cache_we = req_hit & cpu_we;
        end
        WRITEBACK: begin
          stall        = 1'b1;
          mem_we       = 1'b1;
          mem_addr_sel = 1'b1;
        end
        FILL: begin
          stall = 1'b1;
        end
        UPDATE: begin
          stall        = 1'b1;
          cache_update = 1'b1;
        end
        default: begin
          stall = 1'b0;
        end
      endcase
    end
  end

`ifdef DCACHE_PERF_COUNTERS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Performance counters. Both wrap naturally at 2^32.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      if (req_hit) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (req_miss) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller.
// Two instances are driven independently: dut0 uses MEM_LATENCY=1 and dut1 uses MEM_LATENCY=4.
// A reference model predicts the outputs. When it sees a miss, it plans the full list of
// expected per-cycle outputs for that miss. When no plan is pending, it answers directly
// from the IDLE rules.
module tb_dcache_controller;

`ifdef DCACHE_PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst   [2];
  logic        re    [2];
  logic        we    [2];
  logic        hit_i [2];
  logic        vd    [2];
  logic        st    [2];
  logic        cwe   [2];
  logic        cupd  [2];
  logic        mwe   [2];
  logic        msel  [2];
  logic [31:0] hc    [2];
  logic [31:0] mc    [2];

  int total = 0;
  int bad   = 0;

  // Model state.
  int          lat  [2] = '{1, 4};
  logic [4:0]  plan [2][0:39];
  int          plen [2] = '{0, 0};
  int          ppos [2] = '{0, 0};
  logic [31:0] mhit [2] = '{0, 0};
  logic [31:0] mmiss[2] = '{0, 0};

  // Observed activity per scenario, counted only outside reset.
  int nst [2];
  int nmwe[2];
  int nupd[2];
  int ncwe[2];

  always #5 clk = ~clk;

  dcache_controller #(.MEM_LATENCY(1)) u0 (
    .CLK(clk), .RST(rst[0]), .cpu_re(re[0]), .cpu_we(we[0]), .hit(hit_i[0]),
    .victim_dirty(vd[0]), .stall(st[0]), .cache_we(cwe[0]), .cache_update(cupd[0]),
    .mem_we(mwe[0]), .mem_addr_sel(msel[0]), .hit_count(hc[0]), .miss_count(mc[0])
  );

  dcache_controller #(.MEM_LATENCY(4)) u1 (
    .CLK(clk), .RST(rst[1]), .cpu_re(re[1]), .cpu_we(we[1]), .hit(hit_i[1]),
    .victim_dirty(vd[1]), .stall(st[1]), .cache_we(cwe[1]), .cache_update(cupd[1]),
    .mem_we(mwe[1]), .mem_addr_sel(msel[1]), .hit_count(hc[1]), .miss_count(mc[1])
  );

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d @%0t: got %h want %h", name, d, $time, act, exp);
    end
  endtask

  // Compare, then advance the model. The check runs on the falling edge, where the inputs
  // are stable.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin : per_dut
      logic [4:0] e;
      logic [4:0] a;
      logic       rq;
      rq = re[d] | we[d];
      if (rst[d])                e = 5'b00000;
      else if (ppos[d] < plen[d]) e = plan[d][ppos[d]];
      else if (!rq)              e = 5'b00000;
      else if (hit_i[d])         e = {1'b0, we[d], 3'b000};
      else                       e = 5'b10000;
      // Output vector layout: {stall, cache_we, cache_update, mem_we, mem_addr_sel}.
      a = {st[d], cwe[d], cupd[d], mwe[d], msel[d]};
      chk("outputs", d, {27'd0, a}, {27'd0, e});
      chk("hit_count", d, hc[d], PERF ? mhit[d] : 32'd0);
      chk("miss_count", d, mc[d], PERF ? mmiss[d] : 32'd0);
      if (!rst[d]) begin
        nst[d]  += int'(st[d]);
        nmwe[d] += int'(mwe[d]);
        nupd[d] += int'(cupd[d]);
        ncwe[d] += int'(cwe[d]);
      end
      if (rst[d]) begin
        plen[d] = 0; ppos[d] = 0; mhit[d] = 0; mmiss[d] = 0;
      end else if (ppos[d] < plen[d]) begin
        ppos[d]++;
      end else if (rq && hit_i[d]) begin
        mhit[d]++;
      end else if (rq) begin
        mmiss[d]++;
        plen[d] = 0; ppos[d] = 0;
        if (vd[d]) for (int i = 0; i < lat[d]; i++) plan[d][plen[d]++] = 5'b10011;
        for (int i = 0; i < lat[d]; i++) plan[d][plen[d]++] = 5'b10000;
        plan[d][plen[d]++] = 5'b10100;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set(input int d, input bit r, input bit w, input bit h, input bit v);
    re[d] = r; we[d] = w; hit_i[d] = h; vd[d] = v;
  endtask

  task automatic clr();
    for (int d = 0; d < 2; d++) begin
      nst[d] = 0; nmwe[d] = 0; nupd[d] = 0; ncwe[d] = 0;
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      set(d, 0, 0, 0, 0);
    end
    clr();
    cyc(2);
    rst[0] = 1'b0; rst[1] = 1'b0;
    cyc(1);

    // Three load hits: no stall, no cache write.
    clr(); set(0, 1, 0, 1, 0); cyc(3); set(0, 0, 0, 0, 0); cyc(1);
    chk("hit_stall", 0, nst[0], 0);
    chk("hit_cwe", 0, ncwe[0], 0);
    chk("hit_cnt3", 0, hc[0], PERF ? 32'd3 : 32'd0);

    // Clean load miss: miss cycle, FILL, UPDATE, then a retry that hits.
    clr(); set(0, 1, 0, 0, 0); cyc(3); set(0, 1, 0, 1, 0); cyc(1); set(0, 0, 0, 0, 0); cyc(1);
    chk("clean_stall", 0, nst[0], 3);
    chk("clean_upd", 0, nupd[0], 1);
    chk("clean_memwe", 0, nmwe[0], 0);
    chk("clean_miss", 0, mc[0], PERF ? 32'd1 : 32'd0);
    chk("clean_hits", 0, hc[0], PERF ? 32'd4 : 32'd0);

    // Dirty store miss. victim_dirty drops mid-miss and must be ignored.
    clr(); set(0, 0, 1, 0, 1); cyc(1); set(0, 0, 1, 0, 0); cyc(3);
    set(0, 0, 1, 1, 0); cyc(1); set(0, 0, 0, 0, 0); cyc(1);
    chk("dirty_stall", 0, nst[0], 4);
    chk("dirty_memwe", 0, nmwe[0], 1);
    chk("dirty_cwe", 0, ncwe[0], 1);
    chk("dirty_upd", 0, nupd[0], 1);

    // MEM_LATENCY=4 dirty miss with re and we both high (treated as a store).
    // Expect 9 stall cycles after the miss cycle.
    clr(); set(1, 1, 1, 0, 1); cyc(10); set(1, 1, 1, 1, 0); cyc(1); set(1, 0, 0, 0, 0); cyc(1);
    chk("lat4_memwe", 1, nmwe[1], 4);
    chk("lat4_stall", 1, nst[1], 10);
    chk("lat4_cwe", 1, ncwe[1], 1);
    chk("lat4_miss", 1, mc[1], PERF ? 32'd1 : 32'd0);

    // Reset asserted during FILL of a dirty miss.
    clr(); set(1, 0, 1, 0, 1); cyc(7);
    rst[1] = 1'b1; cyc(1); rst[1] = 1'b0; set(1, 0, 0, 0, 0); cyc(2);
    chk("rst_noupd", 1, nupd[1], 0);
    chk("rst_hits", 1, hc[1], 32'd0);
    chk("rst_miss", 1, mc[1], 32'd0);

    // Request dropped during WRITEBACK: FILL and UPDATE still run to completion.
    clr(); set(0, 0, 1, 0, 1); cyc(1); set(0, 0, 0, 0, 0); cyc(4);
    chk("drop_upd", 0, nupd[0], 1);
    chk("drop_memwe", 0, nmwe[0], 1);
    chk("drop_cwe", 0, ncwe[0], 0);

    // No request present: hit and victim_dirty must be ignored.
    clr(); set(0, 0, 0, 1, 1); cyc(2); set(0, 0, 0, 0, 0);
    chk("idle_stall", 0, nst[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
